avalon_input_capture: RTL
=========================

Name: avalon_input_capture

Overview:
- Avalon-MM slave that reads the board's pushbuttons and slide switches on behalf of the HPS.
- Provides synchronisation, per-key debounce, edge capture and a maskable interrupt.
- Sits in the FPGA fabric next to the output PIOs (LEDs, HEX) and adds a proper read path for user inputs.
- Raw active-low KEY pins and SW pins enter directly. The lightweight HPS bridge reads four word registers.

Parameters:
- NUM_KEYS, 4, number of pushbuttons (at most 32).
- NUM_SW, 10, number of slide switches (at most 32).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a key change (10 ms at 50 MHz).
- CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- key_n  in  NUM_KEYS  raw pushbuttons, active-low, asynchronous.
- sw  in  NUM_SW  raw slide switches, asynchronous.
- avs_address  in  2  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- irq  out  1  level interrupt, active-high, registered.

Behaviour:
- Register map (word offsets):
  - 0 KEYS (RO): debounced key state, 1 = pressed, in bits [NUM_KEYS-1:0].
  - 1 SW (RO): synchronised switch state in bits [NUM_SW-1:0].
  - 2 MASK (RW): interrupt mask in bits [NUM_KEYS-1:0].
  - 3 EDGE (R/W1C): press-edge capture in bits [NUM_KEYS-1:0].
  - Unused upper bits read 0; writes to offsets 0 and 1 are ignored.
- Reset (reset_n low at a clk edge): the following all go to 0.
  - synchroniser flops (held as pressed = 0 for keys)
  - debounced state, debounce counters
  - MASK, EDGE
  - avs_readdata, irq
- Synchroniser:
  - Two flops per input bit.
  - key_n is inverted before synchronising, so internal key = ~key_n.
- Debounce, per key, independently:
  - If sync bit equals the stable bit, counter clears to 0.
  - Otherwise counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable bit takes the sync value on that edge and the counter clears.
  - Pin-to-KEYS latency = 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES is ignored.
- Switches are synchronised only, not debounced; latency is 2 cycles.
- Edge capture:
  - EDGE[i] sets on the cycle after stable[i] goes 0->1 (press). Release does not set it.
  - Writing offset 3 clears every bit where writedata = 1.
  - If a set and a clear hit the same bit in the same cycle, set wins (bit = 1).
- irq:
  - Registered |(EDGE & MASK), so it changes one cycle after EDGE or MASK changes.
  - A MASK write takes effect on the next edge.
- Reads:
  - avs_readdata is valid exactly 1 cycle after avs_read is sampled high (fixed read latency 1, no waitrequest).
  - It holds its last value otherwise.
  - Reads have no side effects; EDGE is not clear-on-read.
- avs_read and avs_write are never asserted together. If they are, the write executes and readdata still updates.
- Reset mid-debounce abandons the pending change. A key held through reset is re-detected as a press after the full latency, and EDGE sets.

Decomposition:
- Shared package avalon_input_capture_pkg holds:
  - register offset constants REG_KEYS=0, REG_SW=1, REG_MASK=2, REG_EDGE=3
  - default DEBOUNCE_CYCLES constant
- One sub-module, debounce_bit (synchroniser + counter + stable flop, parameterised by DEBOUNCE_CYCLES and CNT_W), instantiated NUM_KEYS times via generate.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
1. Reset then read offsets 0-3 -> all return 0x0; irq=0.
2. key_n[0] driven low and held -> KEYS reads 0x1 from cycle 6 after the pin change; EDGE reads 0x1; irq stays 0 (MASK=0).
3. key_n[2] low for 3 cycles then high -> KEYS and EDGE stay 0x0.
4. Write MASK=0x2, press key1 -> irq rises one cycle after EDGE[1] sets. Write EDGE=0x2 -> irq falls one cycle after the write; EDGE reads 0x0.
5. EDGE[3] set event in the same cycle as a W1C write of 0x8 -> EDGE reads 0x8 afterward.
6. sw=10'h2A5 -> read offset 1 issued 2 cycles later returns 0x000002A5 one cycle after avs_read.

Source files
------------

// File: rtl/avalon_input_capture_pkg.sv
// Shared register map and default timing for the pushbutton/switch capture slave.
package avalon_input_capture_pkg;

    localparam logic [1:0] REG_KEYS = 2'd0;
    localparam logic [1:0] REG_SW   = 2'd1;
    localparam logic [1:0] REG_MASK = 2'd2;
    localparam logic [1:0] REG_EDGE = 2'd3;

    // 10 ms of stability at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchroniser, then a stability counter that only
// lets the accepted level follow the input after DEBOUNCE_CYCLES agreeing samples.
module debounce_bit
    import avalon_input_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] count;

    // Any sample that agrees with the accepted level restarts the stability window
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            count  <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            if (sync == stable) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                stable <= sync;
                count  <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/avalon_input_capture.sv
// Avalon-MM slave exposing debounced pushbuttons, synchronised switches,
// press-edge capture with write-one-to-clear, and a maskable level interrupt.
module avalon_input_capture
    import avalon_input_capture_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SW          = 10,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 19
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_SW-1:0]   sw,
    input  logic [1:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                irq
);

    logic [NUM_KEYS-1:0] key_stable;
    logic [NUM_KEYS-1:0] key_stable_d;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] edge_capture;
    logic [NUM_KEYS-1:0] edge_clear;
    logic [NUM_KEYS-1:0] key_mask;
    logic [NUM_SW-1:0]   sw_meta;
    logic [NUM_SW-1:0]   sw_sync;
    logic [31:0]         read_mux;

    // Keys are inverted before synchronising so that 1 means pressed throughout
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (~key_n[i]),
            .stable (key_stable[i])
        );
    end

    if (NUM_KEYS < 32) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^avs_writedata[31:NUM_KEYS];
    end

    assign press      = key_stable & ~key_stable_d;
    assign edge_clear = (avs_write && avs_address == REG_EDGE) ?
                        avs_writedata[NUM_KEYS-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    always_comb begin
        read_mux = '0;
        case (avs_address)
            REG_KEYS: read_mux[NUM_KEYS-1:0] = key_stable;
            REG_SW:   read_mux[NUM_SW-1:0]   = sw_sync;
            REG_MASK: read_mux[NUM_KEYS-1:0] = key_mask;
            REG_EDGE: read_mux[NUM_KEYS-1:0] = edge_capture;
        endcase
    end

    // A press arriving in the same cycle as a clear of that bit keeps the bit set
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_stable_d <= '0;
            edge_capture <= '0;
            key_mask     <= '0;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            key_stable_d <= key_stable;
            edge_capture <= (edge_capture & ~edge_clear) | press;
            if (avs_write && avs_address == REG_MASK) begin
                key_mask <= avs_writedata[NUM_KEYS-1:0];
            end
            irq <= |(edge_capture & key_mask);
            if (avs_read) begin
                avs_readdata <= read_mux;
            end
        end
    end

endmodule
